// File: rtl/x7seg_mux_n.sv
`default_nettype none
// ============================================================================
// Module   : x7seg_mux_n
// Purpose  : Multiplexed seven-segment driver for DIGITS common-anode hex
//            digits. Input values are latched once per frame, so a digit
//            never shows a mix of old and new data. Also provides per-digit
//            decimal points, leading-zero blanking and 16-level PWM
//            brightness.
//
// Parameters
//   DIGITS   : number of digits, 1..8
//   DIV_BITS : prescaler width; one digit slot lasts 2^DIV_BITS cycles (>= 4)
//
// Ports
//   clk      in   system clock, rising-edge
//   clr      in   synchronous active-high reset
//   x        in   4*DIGITS  hex value; nibble i drives digit i (0 = rightmost)
//   dp_in    in   DIGITS    decimal point request per digit, 1 = lit
//   blank_lz in   1         1 = suppress leading zeros
//   bright   in   4         brightness, 0 = 1/16 duty, 15 = full
//   a_to_g   out  7         segments, active-low, bit 6 = a .. bit 0 = g
//   dp       out  1         decimal point, active-low
//   an       out  DIGITS    digit enables, active-low, at most one low
//
// Revision : 1.0  initial release
// ============================================================================
module x7seg_mux_n #(
    parameter int DIGITS   = 4,
    parameter int DIV_BITS = 18
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [4*DIGITS-1:0]   x,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    input  logic [3:0]            bright,
    output logic [6:0]            a_to_g,
    output logic                  dp,
    output logic [DIGITS-1:0]     an
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // idx needs at least one bit even for a single-digit display.
    localparam int c_idx_w = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [c_idx_w-1:0]  c_last_idx = c_idx_w'(DIGITS - 1);
    localparam logic [c_idx_w-1:0]  c_idx_one  = c_idx_w'(1);
    localparam logic [DIV_BITS-1:0] c_q_one    = DIV_BITS'(1);
    localparam logic [6:0]          c_seg_off  = 7'b1111111;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DIV_BITS-1:0]  r_q;      // prescaler / in-slot position
    logic [c_idx_w-1:0]   r_idx;    // digit currently being scanned
    logic [4*DIGITS-1:0]  r_sx;     // shadow copy of x for this frame
    logic [DIGITS-1:0]    r_sdp;    // shadow copy of dp_in for this frame
    logic                 r_init;   // set by reset, cleared by first load
    logic [6:0]           r_seg;
    logic                 r_dp;
    logic [DIGITS-1:0]    r_an;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic                 w_tick;
    logic                 w_frame_end;
    logic                 w_on;
    logic [3:0]           w_nib;
    logic                 w_sdp_bit;
    logic                 w_zero_above;
    logic [DIGITS-1:0]    w_upper_zero;
    logic                 w_run_zero;
    logic [DIGITS-1:0]    w_an_sel;
    logic [6:0]           w_seg_dec;
    logic                 w_lz_blank;
    logic [6:0]           w_seg_next;
    logic                 w_dp_next;
    logic [DIGITS-1:0]    w_an_next;

    // End of a digit slot, and end of the last slot of the frame.
    assign w_tick      = &r_q;
    assign w_frame_end = w_tick && (r_idx == c_last_idx);

    // PWM: the digit is lit during the first (bright+1)/16 of its slot,
    // judged by the top four bits of the prescaler.
    assign w_on = (r_q[DIV_BITS-1 -: 4] <= bright);

    // ------------------------------------------------------------------------
    // Leading-zero detection: w_upper_zero[i] is set when shadow nibbles
    // i..DIGITS-1 are all zero. Built from the top digit downwards.
    // ------------------------------------------------------------------------
    always_comb begin
        w_upper_zero = '0;
        w_run_zero   = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_run_zero      = w_run_zero && (r_sx[4*i +: 4] == 4'h0);
            w_upper_zero[i] = w_run_zero;
        end
    end

    // ------------------------------------------------------------------------
    // Select the per-digit data for the current scan index.
    // ------------------------------------------------------------------------
    always_comb begin
        w_nib        = 4'h0;
        w_sdp_bit    = 1'b0;
        w_zero_above = 1'b0;
        w_an_sel     = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == c_idx_w'(i)) begin
                w_nib        = r_sx[4*i +: 4];
                w_sdp_bit    = r_sdp[i];
                w_zero_above = w_upper_zero[i];
                w_an_sel[i]  = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Hex to active-low segment decode (bit 6 = a .. bit 0 = g).
    // ------------------------------------------------------------------------
    always_comb begin
        w_seg_dec = c_seg_off;
        case (w_nib)
            4'h0:    w_seg_dec = 7'b0000001;
            4'h1:    w_seg_dec = 7'b1001111;
            4'h2:    w_seg_dec = 7'b0010010;
            4'h3:    w_seg_dec = 7'b0000110;
            4'h4:    w_seg_dec = 7'b1001100;
            4'h5:    w_seg_dec = 7'b0100100;
            4'h6:    w_seg_dec = 7'b0100000;
            4'h7:    w_seg_dec = 7'b0001111;
            4'h8:    w_seg_dec = 7'b0000000;
            4'h9:    w_seg_dec = 7'b0000100;
            4'hA:    w_seg_dec = 7'b0001000;
            4'hB:    w_seg_dec = 7'b1100000;
            4'hC:    w_seg_dec = 7'b0110001;
            4'hD:    w_seg_dec = 7'b1000010;
            4'hE:    w_seg_dec = 7'b0110000;
            4'hF:    w_seg_dec = 7'b0111000;
            default: w_seg_dec = c_seg_off;
        endcase
    end

    // Digit 0 is never blanked so a zero value still shows a single "0".
    // A blanked digit keeps its anode and decimal point behaviour.
    assign w_lz_blank = blank_lz && (r_idx != '0) && w_zero_above;

    // ------------------------------------------------------------------------
    // Next output values.
    // ------------------------------------------------------------------------
    always_comb begin
        w_an_next  = '1;
        w_seg_next = c_seg_off;
        w_dp_next  = 1'b1;
        if (w_on) begin
            w_an_next  = w_an_sel;
            w_seg_next = w_lz_blank ? c_seg_off : w_seg_dec;
            w_dp_next  = ~w_sdp_bit;
        end
    end

    // ------------------------------------------------------------------------
    // Sequential logic.
    //
    // The first cycle after reset is a pure load cycle: the shadows capture
    // x/dp_in, while the prescaler and index hold and the outputs stay dark.
    // This way the following edge shows digit 0 of the freshly loaded value
    // for a full slot, instead of briefly showing the cleared shadow.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr) begin
            r_q    <= '0;
            r_idx  <= '0;
            r_sx   <= '0;
            r_sdp  <= '0;
            r_init <= 1'b1;
            r_an   <= '1;
            r_seg  <= c_seg_off;
            r_dp   <= 1'b1;
        end else if (r_init) begin
            r_sx   <= x;
            r_sdp  <= dp_in;
            r_init <= 1'b0;
            r_an   <= '1;
            r_seg  <= c_seg_off;
            r_dp   <= 1'b1;
        end else begin
            r_q <= r_q + c_q_one;

            if (w_tick) begin
                if (r_idx == c_last_idx) begin
                    r_idx <= '0;
                end else begin
                    r_idx <= r_idx + c_idx_one;
                end
            end

            // Shadow reload coincides with the index wrap, so the first
            // digit of the new frame already uses the new value.
            if (w_frame_end) begin
                r_sx  <= x;
                r_sdp <= dp_in;
            end

            r_an  <= w_an_next;
            r_seg <= w_seg_next;
            r_dp  <= w_dp_next;
        end
    end

    assign a_to_g = r_seg;
    assign dp     = r_dp;
    assign an     = r_an;

endmodule
`default_nettype wire

// File: tb/tb_x7seg_mux_n.sv
`default_nettype none
module tb_x7seg_mux_n;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       clr      = 1'b1;
    logic       blank_lz = 1'b1;
    logic [3:0] bright   = 4'hF;

    logic [15:0] x4  = '0;
    logic [3:0]  dp4 = '0;
    logic [6:0]  seg4;
    logic        dpo4;
    logic [3:0]  an4;

    logic [3:0]  x1  = '0;
    logic [0:0]  dp1 = '0;
    logic [6:0]  seg1;
    logic        dpo1;
    logic [0:0]  an1;

    logic [31:0] x8  = '0;
    logic [7:0]  dp8 = '0;
    logic [6:0]  seg8;
    logic        dpo8;
    logic [7:0]  an8;

    x7seg_mux_n #(.DIGITS(4), .DIV_BITS(4)) u_dut4 (
        .clk(clk), .clr(clr), .x(x4), .dp_in(dp4), .blank_lz(blank_lz),
        .bright(bright), .a_to_g(seg4), .dp(dpo4), .an(an4));

    x7seg_mux_n #(.DIGITS(1), .DIV_BITS(4)) u_dut1 (
        .clk(clk), .clr(clr), .x(x1), .dp_in(dp1), .blank_lz(blank_lz),
        .bright(bright), .a_to_g(seg1), .dp(dpo1), .an(an1));

    x7seg_mux_n #(.DIGITS(8), .DIV_BITS(4)) u_dut8 (
        .clk(clk), .clr(clr), .x(x8), .dp_in(dp8), .blank_lz(blank_lz),
        .bright(bright), .a_to_g(seg8), .dp(dpo8), .an(an8));

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    typedef struct {
        logic [15:0] xv;
        logic [3:0]  dpv;
        logic        blz;
        logic [3:0]  br;
        int          t;
        logic [7:0]  an;
        logic [6:0]  seg;
        logic        dp;
    } vec_t;

    exp_t sbq[$];
    int checks   = 0;
    int failures = 0;

    // Reference state (arithmetic on cycles since the load cycle).
    int          sel    = 4;
    int          m_t    = 0;
    bit          m_init = 1'b1;
    logic [31:0] m_sx   = '0;
    logic [7:0]  m_sdp  = '0;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;  default: return 7'b0111000;
        endcase
    endfunction

    function automatic logic [31:0] cur_x();
        if (sel == 1) return {28'h0, x1};
        if (sel == 4) return {16'h0, x4};
        return x8;
    endfunction

    function automatic logic [7:0] cur_dp();
        if (sel == 1) return {7'h0, dp1};
        if (sel == 4) return {4'h0, dp4};
        return dp8;
    endfunction

    // Expected output for the coming edge, given inputs as they are now.
    task automatic model_step(output exp_t e);
        int s, qv, d;
        logic [7:0] mask;
        mask  = (sel == 8) ? 8'hFF : (sel == 4) ? 8'h0F : 8'h01;
        e.an  = mask;
        e.seg = 7'b1111111;
        e.dp  = 1'b1;
        if (clr) begin
            m_init = 1'b1;
            m_t    = 0;
            m_sx   = '0;
            m_sdp  = '0;
        end else if (m_init) begin
            m_sx   = cur_x();
            m_sdp  = cur_dp();
            m_init = 1'b0;
            m_t    = 0;
        end else begin
            s  = m_t;
            qv = s % 16;
            d  = (s / 16) % sel;
            if (qv <= int'(bright)) begin
                e.an  = mask & ~(8'd1 << d);
                e.seg = (blank_lz && d != 0 && (m_sx >> (4 * d)) == 32'h0)
                        ? 7'b1111111 : seg_of(m_sx[4*d +: 4]);
                e.dp  = ~m_sdp[d];
            end
            if (qv == 15 && d == sel - 1) begin
                m_sx  = cur_x();
                m_sdp = cur_dp();
            end
            m_t++;
        end
    endtask

    task automatic check_cycle(input string name, input exp_t e, input bit chk);
        exp_t g;
        logic [7:0] a_an;
        logic [6:0] a_seg;
        logic       a_dp;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        g = sbq.pop_front();
        if (sel == 1) begin
            a_an = {7'h0, an1}; a_seg = seg1; a_dp = dpo1;
        end else if (sel == 4) begin
            a_an = {4'h0, an4}; a_seg = seg4; a_dp = dpo4;
        end else begin
            a_an = an8; a_seg = seg8; a_dp = dpo8;
        end
        if (chk) begin
            checks++;
            if (a_an !== g.an || a_seg !== g.seg || a_dp !== g.dp) begin
                failures++;
                $display("FAIL %s: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                         name, a_an, a_seg, a_dp, g.an, g.seg, g.dp);
            end
        end
    endtask

    task automatic run(input string name, input int n, input bit chk);
        exp_t e;
        repeat (n) begin
            model_step(e);
            check_cycle(name, e, chk);
        end
    endtask

    task automatic count_check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    vec_t tv[20];

    initial begin
        exp_t e, te;
        int   cnt, dcnt;

        //        x         dp    blz   br     t   an      seg          dp
        tv[0]  = '{16'h007F, 4'h0, 1'b1, 4'hF,  0, 8'h0F, 7'b1111111, 1'b1};
        tv[1]  = '{16'h007F, 4'h0, 1'b1, 4'hF,  1, 8'h0E, 7'b0111000, 1'b1};
        tv[2]  = '{16'h007F, 4'h0, 1'b1, 4'hF, 16, 8'h0E, 7'b0111000, 1'b1};
        tv[3]  = '{16'h007F, 4'h0, 1'b1, 4'hF, 17, 8'h0D, 7'b0001111, 1'b1};
        tv[4]  = '{16'h007F, 4'h0, 1'b1, 4'hF, 32, 8'h0D, 7'b0001111, 1'b1};
        tv[5]  = '{16'h007F, 4'h0, 1'b1, 4'hF, 33, 8'h0B, 7'b1111111, 1'b1};
        tv[6]  = '{16'h007F, 4'h0, 1'b1, 4'hF, 49, 8'h07, 7'b1111111, 1'b1};
        tv[7]  = '{16'h007F, 4'h0, 1'b0, 4'hF, 33, 8'h0B, 7'b0000001, 1'b1};
        tv[8]  = '{16'h007F, 4'h0, 1'b0, 4'hF, 49, 8'h07, 7'b0000001, 1'b1};
        tv[9]  = '{16'h0000, 4'h0, 1'b1, 4'hF,  1, 8'h0E, 7'b0000001, 1'b1};
        tv[10] = '{16'h0000, 4'h0, 1'b1, 4'hF, 17, 8'h0D, 7'b1111111, 1'b1};
        tv[11] = '{16'h1234, 4'h0, 1'b1, 4'h3, 20, 8'h0D, 7'b0000110, 1'b1};
        tv[12] = '{16'h1234, 4'h0, 1'b1, 4'h3, 21, 8'h0F, 7'b1111111, 1'b1};
        tv[13] = '{16'h1234, 4'h0, 1'b1, 4'h0,  1, 8'h0E, 7'b1001100, 1'b1};
        tv[14] = '{16'h1234, 4'h0, 1'b1, 4'h0,  2, 8'h0F, 7'b1111111, 1'b1};
        tv[15] = '{16'h1234, 4'h4, 1'b1, 4'hF, 33, 8'h0B, 7'b0010010, 1'b0};
        tv[16] = '{16'h1234, 4'h4, 1'b1, 4'hF, 17, 8'h0D, 7'b0000110, 1'b1};
        tv[17] = '{16'h1234, 4'h0, 1'b1, 4'hF, 64, 8'h07, 7'b1001111, 1'b1};
        tv[18] = '{16'h1234, 4'h0, 1'b1, 4'hF, 65, 8'h0E, 7'b1001100, 1'b1};
        tv[19] = '{16'h0102, 4'h0, 1'b1, 4'hF, 17, 8'h0D, 7'b0000001, 1'b1};

        // Reset state
        sel = 4;
        clr = 1'b1;
        run("reset_state", 3, 1'b1);

        // Table-driven probes
        for (int i = 0; i < 20; i++) begin
            x4 = tv[i].xv; dp4 = tv[i].dpv; blank_lz = tv[i].blz; bright = tv[i].br;
            clr = 1'b1;
            run("vec_reset", 2, 1'b1);
            clr = 1'b0;
            te.an = tv[i].an; te.seg = tv[i].seg; te.dp = tv[i].dp;
            for (int k = 0; k <= tv[i].t; k++) begin
                model_step(e);
                if (k == tv[i].t) check_cycle($sformatf("vec%0d_t%0d", i, k), te, 1'b1);
                else              check_cycle("skip", e, 1'b0);
            end
        end

        // Tear-free latching: change x during the digit-1 slot
        x4 = 16'h1234; dp4 = 4'h0; blank_lz = 1'b1; bright = 4'hF;
        clr = 1'b1;
        run("tear_reset", 2, 1'b1);
        clr = 1'b0;
        run("tear_pre", 20, 1'b1);
        x4 = 16'hABCD;
        run("tear_post", 110, 1'b1);

        // PWM duty and decimal point
        x4 = 16'h1234; dp4 = 4'b0100; bright = 4'h3;
        clr = 1'b1;
        run("pwm_reset", 2, 1'b1);
        clr = 1'b0;
        run("pwm_lead", 17, 1'b1);
        cnt = 0;
        for (int k = 0; k < 16; k++) begin
            model_step(e);
            check_cycle("pwm_b3", e, 1'b1);
            if (an4 != 4'hF) cnt++;
        end
        count_check("pwm_b3_low_cycles", cnt, 4);
        bright = 4'h0;
        cnt = 0; dcnt = 0;
        for (int k = 0; k < 16; k++) begin
            model_step(e);
            check_cycle("pwm_b0", e, 1'b1);
            if (an4 != 4'hF) cnt++;
            if (dpo4 == 1'b0 && an4 == 4'b1011) dcnt++;
        end
        count_check("pwm_b0_low_cycles", cnt, 1);
        count_check("dp_digit2_low_cycles", dcnt, 1);

        // Reset during the digit-2 slot, new x applied with the reset
        x4 = 16'h1234; dp4 = 4'h0; bright = 4'hF; blank_lz = 1'b0;
        clr = 1'b1;
        run("mid_reset_pre", 2, 1'b1);
        clr = 1'b0;
        run("mid_run", 41, 1'b1);
        x4  = 16'h5678;
        clr = 1'b1;
        run("mid_reset", 1, 1'b1);
        clr = 1'b0;
        run("mid_restart", 40, 1'b1);

        // Single digit
        sel = 1; x1 = 4'h9; dp1 = 1'b0; blank_lz = 1'b1; bright = 4'hF;
        clr = 1'b1;
        run("d1_reset", 2, 1'b1);
        clr = 1'b0;
        run("d1_scan", 40, 1'b1);

        // Eight digits with leading-zero blanking and decimal points
        sel = 8; x8 = 32'h00A1_B2C3; dp8 = 8'h81; blank_lz = 1'b1; bright = 4'hF;
        clr = 1'b1;
        run("d8_reset", 2, 1'b1);
        clr = 1'b0;
        run("d8_scan", 140, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
